// File: rtl/scarv_cop_issue.sv
`default_nettype none
// ============================================================================
// Module   : scarv_cop_issue
// Brief    : Coprocessor instruction queue, dispatch FSM and response register.
// Revision : 1.0
// ============================================================================
module scarv_cop_issue #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cpu_insn_req,
  output logic        cpu_insn_ack,
  input  logic [31:0] cpu_insn_enc,
  input  logic [31:0] cpu_rs1_val,
  input  logic        cpu_flush,
  output logic        cpu_rsp_valid,
  input  logic        cpu_rsp_ack,
  output logic        cpu_rsp_wen,
  output logic [4:0]  cpu_rsp_rd,
  output logic [31:0] cpu_rsp_wdata,
  output logic [2:0]  cpu_rsp_status,
  output logic [31:0] id_encoded,
  output logic [31:0] id_rs1_val,
  input  logic        id_exception,
  output logic        id_valid,
  input  logic        id_ready,
  input  logic        cop_done,
  input  logic        cop_wen,
  input  logic [4:0]  cop_rd,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_status
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_enc [FIFO_DEPTH];
  logic [31:0]   r_rs1 [FIFO_DEPTH];
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_wptr;
  logic [CW-1:0] r_count;

  logic          r_rsp_valid;
  logic          r_rsp_wen;
  logic [4:0]    r_rsp_rd;
  logic [31:0]   r_rsp_wdata;
  logic [2:0]    r_rsp_status;

  logic w_empty;
  logic w_full;
  logic w_idle;
  logic w_push;
  logic w_dispatch;
  logic w_illegal;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_idle  = (r_state == S_IDLE);

  // Reset gating keeps the handshakes quiet for the whole reset pulse.
  assign cpu_insn_ack = !g_reset && !w_full && !cpu_flush;
  assign w_push       = cpu_insn_req && cpu_insn_ack;

  assign id_encoded = w_empty ? 32'd0 : r_enc[r_rptr];
  assign id_rs1_val = w_empty ? 32'd0 : r_rs1[r_rptr];

  assign id_valid   = !g_reset && w_idle && !w_empty && !id_exception && !cpu_flush;
  assign w_dispatch = id_valid && id_ready;
  assign w_illegal  = !g_reset && w_idle && !w_empty && id_exception && !cpu_flush;
  assign w_pop      = w_dispatch || w_illegal;

  always_ff @(posedge g_clk) begin
    if (w_push) begin
      r_enc[r_wptr] <= cpu_insn_enc;
      r_rs1[r_wptr] <= cpu_rs1_val;
    end
  end

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (cpu_flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state      <= S_IDLE;
      r_rsp_valid  <= 1'b0;
      r_rsp_wen    <= 1'b0;
      r_rsp_rd     <= 5'd0;
      r_rsp_wdata  <= 32'd0;
      r_rsp_status <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dispatch) begin
            r_state <= S_WAIT;
          end else if (w_illegal) begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_wen    <= 1'b0;
            r_rsp_rd     <= id_encoded[11:7];
            r_rsp_wdata  <= 32'd0;
            r_rsp_status <= 3'b001;
          end
        end
        S_WAIT: begin
          if (cop_done) begin
            r_state      <= S_RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_wen    <= cop_wen;
            r_rsp_rd     <= cop_rd;
            r_rsp_wdata  <= cop_wdata;
            r_rsp_status <= cop_status;
          end
        end
        S_RESP: begin
          if (cpu_rsp_ack) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_rsp_valid  = r_rsp_valid;
  assign cpu_rsp_wen    = r_rsp_wen && (r_rsp_rd != 5'd0);
  assign cpu_rsp_rd     = r_rsp_rd;
  assign cpu_rsp_wdata  = r_rsp_wdata;
  assign cpu_rsp_status = r_rsp_status;

endmodule
`default_nettype wire

// File: tb/tb_scarv_cop_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_scarv_cop_issue
// Brief    : Scoreboard bench for the coprocessor issue block.
// Revision : 1.0
// ============================================================================
module tb_scarv_cop_issue;

  localparam int DEPTH = 2;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        cpu_insn_req = 1'b0;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc = '0;
  logic [31:0] cpu_rs1_val = '0;
  logic        cpu_flush = 1'b0;
  logic        cpu_rsp_valid;
  logic        cpu_rsp_ack = 1'b0;
  logic        cpu_rsp_wen;
  logic [4:0]  cpu_rsp_rd;
  logic [31:0] cpu_rsp_wdata;
  logic [2:0]  cpu_rsp_status;
  logic [31:0] id_encoded;
  logic [31:0] id_rs1_val;
  logic        id_exception = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic        cop_done = 1'b0;
  logic        cop_wen = 1'b0;
  logic [4:0]  cop_rd = '0;
  logic [31:0] cop_wdata = '0;
  logic [2:0]  cop_status = '0;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [2:0]  st;
  } rsp_t;

  logic [63:0] q_disp [$];
  rsp_t        q_rsp  [$];
  logic [63:0] e_disp;
  rsp_t        e_rsp;
  int          n_checks = 0;
  int          n_fail   = 0;

  scarv_cop_issue #(.FIFO_DEPTH(DEPTH)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1_val(cpu_rs1_val),
    .cpu_flush(cpu_flush),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_ack(cpu_rsp_ack),
    .cpu_rsp_wen(cpu_rsp_wen), .cpu_rsp_rd(cpu_rsp_rd),
    .cpu_rsp_wdata(cpu_rsp_wdata), .cpu_rsp_status(cpu_rsp_status),
    .id_encoded(id_encoded), .id_rs1_val(id_rs1_val),
    .id_exception(id_exception), .id_valid(id_valid), .id_ready(id_ready),
    .cop_done(cop_done), .cop_wen(cop_wen), .cop_rd(cop_rd),
    .cop_wdata(cop_wdata), .cop_status(cop_status)
  );

  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Drives one completion pulse; the expected response obeys the rd=0 write mask.
  task automatic drive_done(input logic wen, input logic [4:0] rd,
                            input logic [31:0] wd, input logic [2:0] st,
                            input logic expect_rsp);
    cop_done = 1'b1; cop_wen = wen; cop_rd = rd; cop_wdata = wd; cop_status = st;
    if (expect_rsp) q_rsp.push_back('{wen && (rd != 5'd0), rd, wd, st});
    tick();
    cop_done = 1'b0;
  endtask

  task automatic test_reset();
    cpu_insn_req = 1'b1;
    cpu_insn_enc = 32'h0000_0F80;
    repeat (2) tick();
    #1;
    n_checks++; if (cpu_insn_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", cpu_insn_ack); end
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_id_valid: got %b want 0", id_valid); end
    n_checks++; if (cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", cpu_rsp_valid); end
    g_reset = 1'b0;
    cpu_insn_req = 1'b0;
    #1;
    n_checks++; if (cpu_insn_ack !== 1'b1) begin n_fail++; $display("FAIL rel_ack: got %b want 1", cpu_insn_ack); end
    n_checks++; if ({id_encoded, cpu_rsp_wdata, cpu_rsp_rd, cpu_rsp_status} !== '0) begin
      n_fail++; $display("FAIL rel_zero: got %h/%h want 0", id_encoded, cpu_rsp_wdata); end
    tick();
  endtask

  task automatic test_basic();
    id_ready = 1'b1;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_002B; cpu_rs1_val = 32'd5;
    #1;
    n_checks++; if (cpu_insn_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b want 1", cpu_insn_ack); end
    q_disp.push_back({cpu_insn_enc, cpu_rs1_val});
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", id_valid); end
    tick();
    cpu_insn_req = 1'b0;
    #1;
    e_disp = q_disp.pop_front();
    n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_id_valid: got %b want 1", id_valid); end
    n_checks++; if ({id_encoded, id_rs1_val} !== e_disp) begin n_fail++; $display("FAIL basic_head: got %h want %h", {id_encoded, id_rs1_val}, e_disp); end
    tick();
    #1;
    n_checks++; if ({id_valid, id_encoded, cpu_rsp_valid} !== '0) begin
      n_fail++; $display("FAIL basic_wait: got valid=%b enc=%h rsp=%b want 0", id_valid, id_encoded, cpu_rsp_valid); end
    drive_done(1'b1, 5'd3, 32'h0000_CAFE, 3'd0, 1'b1);
    #1;
    e_rsp = q_rsp.pop_front();
    n_checks++; if (cpu_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid: got %b want 1", cpu_rsp_valid); end
    n_checks++; if ({cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== e_rsp) begin
      n_fail++; $display("FAIL basic_rsp: got %h want %h", {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}, e_rsp); end
    cpu_rsp_ack = 1'b1;
    tick();
    cpu_rsp_ack = 1'b0;
    #1;
    n_checks++; if (cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_clear: got %b want 0", cpu_rsp_valid); end
  endtask

  task automatic test_full_wrap();
    id_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_insn_req = 1'b1;
      cpu_insn_enc = 32'h0000_1000 + 32'(i) * 32'h80;
      cpu_rs1_val  = 32'd100 + 32'(i);
      #1;
      n_checks++; if (cpu_insn_ack !== 1'b1) begin n_fail++; $display("FAIL full_ack%0d: got %b want 1", i, cpu_insn_ack); end
      q_disp.push_back({cpu_insn_enc, cpu_rs1_val});
      tick();
    end
    cpu_insn_enc = 32'h0000_7777;
    #1;
    n_checks++; if (cpu_insn_ack !== 1'b0) begin n_fail++; $display("FAIL full_ack_block: got %b want 0", cpu_insn_ack); end
    cpu_insn_req = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e_disp = q_disp.pop_front();
      n_checks++; if (id_valid !== 1'b1 || {id_encoded, id_rs1_val} !== e_disp) begin
        n_fail++; $display("FAIL wrap_head%0d: got %b/%h want 1/%h", i, id_valid, {id_encoded, id_rs1_val}, e_disp); end
      tick();
      drive_done(1'b1, 5'(i + 1), $urandom, 3'(i + 2), 1'b1);
      #1;
      e_rsp = q_rsp.pop_front();
      n_checks++; if (cpu_rsp_valid !== 1'b1 || {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== e_rsp) begin
        n_fail++; $display("FAIL wrap_rsp%0d: got %b/%h want 1/%h", i, cpu_rsp_valid, {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}, e_rsp); end
      cpu_rsp_ack = 1'b1;
      tick();
      cpu_rsp_ack = 1'b0;
    end
  endtask

  task automatic test_illegal();
    id_ready = 1'b1;
    id_exception = 1'b1;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0F83; cpu_rs1_val = 32'd9;
    q_rsp.push_back('{1'b0, 5'd31, 32'd0, 3'b001});
    tick();
    cpu_insn_req = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL ill_id_valid: got %b want 0", id_valid); end
    n_checks++; if (id_encoded !== 32'h0000_0F83) begin n_fail++; $display("FAIL ill_head: got %h want 00000f83", id_encoded); end
    tick();
    id_exception = 1'b0;
    e_rsp = q_rsp.pop_front();
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (cpu_rsp_valid !== 1'b1 || {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== e_rsp) begin
        n_fail++; $display("FAIL ill_hold%0d: got %b/%h want 1/%h", c, cpu_rsp_valid, {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}, e_rsp); end
      if (c < 5) tick();
    end
    cpu_rsp_ack = 1'b1;
    tick();
    cpu_rsp_ack = 1'b0;
  endtask

  task automatic test_rd0();
    id_ready = 1'b1;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0033; cpu_rs1_val = 32'd1;
    tick();
    cpu_insn_req = 1'b0;
    tick();
    drive_done(1'b1, 5'd0, 32'h0000_1234, 3'd0, 1'b1);
    #1;
    e_rsp = q_rsp.pop_front();
    n_checks++; if (cpu_rsp_wen !== 1'b0) begin n_fail++; $display("FAIL rd0_wen: got %b want 0", cpu_rsp_wen); end
    n_checks++; if (cpu_rsp_valid !== 1'b1 || {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== e_rsp) begin
      n_fail++; $display("FAIL rd0_rsp: got %h want %h", {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}, e_rsp); end
    cpu_rsp_ack = 1'b1;
    tick();
    cpu_rsp_ack = 1'b0;
  endtask

  task automatic test_flush();
    id_ready = 1'b1;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0200; cpu_rs1_val = 32'd7;
    q_disp.push_back({cpu_insn_enc, cpu_rs1_val});
    tick();
    cpu_insn_req = 1'b0;
    #1;
    e_disp = q_disp.pop_front();
    n_checks++; if (id_valid !== 1'b1 || {id_encoded, id_rs1_val} !== e_disp) begin
      n_fail++; $display("FAIL flush_dispatch: got %b/%h want 1/%h", id_valid, {id_encoded, id_rs1_val}, e_disp); end
    tick();
    for (int i = 0; i < 2; i++) begin
      cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0300 + 32'(i); cpu_rs1_val = 32'(i);
      #1;
      n_checks++; if (cpu_insn_ack !== 1'b1) begin n_fail++; $display("FAIL flush_fill%0d: got %b want 1", i, cpu_insn_ack); end
      q_disp.push_back({cpu_insn_enc, cpu_rs1_val});
      tick();
    end
    cpu_flush = 1'b1;
    cpu_insn_enc = 32'h0000_0DDD;
    #1;
    n_checks++; if (cpu_insn_ack !== 1'b0) begin n_fail++; $display("FAIL flush_ack: got %b want 0", cpu_insn_ack); end
    q_disp.delete();
    tick();
    cpu_flush = 1'b0;
    cpu_insn_req = 1'b0;
    #1;
    n_checks++; if (id_encoded !== 32'd0 || cpu_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty: got enc=%h rsp=%b want 0/0", id_encoded, cpu_rsp_valid); end
    drive_done(1'b1, 5'd4, 32'h0000_A5A5, 3'd0, 1'b1);
    #1;
    e_rsp = q_rsp.pop_front();
    n_checks++; if (cpu_rsp_valid !== 1'b1 || {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== e_rsp) begin
      n_fail++; $display("FAIL flush_rsp: got %b/%h want 1/%h", cpu_rsp_valid, {cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}, e_rsp); end
    cpu_rsp_ack = 1'b1;
    tick();
    cpu_rsp_ack = 1'b0;
    #1;
    n_checks++; if (id_valid !== 1'b0 || id_encoded !== 32'd0) begin
      n_fail++; $display("FAIL flush_idle: got %b/%h want 0/0", id_valid, id_encoded); end
  endtask

  task automatic test_reset_wait();
    id_ready = 1'b1;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0400; cpu_rs1_val = 32'd3;
    tick();
    cpu_insn_req = 1'b0;
    tick();
    g_reset = 1'b1;
    #1;
    n_checks++; if ({cpu_insn_ack, id_valid, cpu_rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rw_in_reset: got %b want 000", {cpu_insn_ack, id_valid, cpu_rsp_valid}); end
    tick();
    g_reset = 1'b0;
    id_ready = 1'b0;
    cpu_insn_req = 1'b1; cpu_insn_enc = 32'h0000_0555; cpu_rs1_val = 32'd11;
    drive_done(1'b1, 5'd7, 32'h0000_FFFF, 3'd2, 1'b0);
    cpu_insn_req = 1'b0;
    #1;
    n_checks++; if ({cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status} !== '0) begin
      n_fail++; $display("FAIL rw_rsp_zero: got %h want 0", {cpu_rsp_valid, cpu_rsp_wen, cpu_rsp_rd, cpu_rsp_wdata, cpu_rsp_status}); end
    n_checks++; if (id_encoded !== 32'h0000_0555 || id_rs1_val !== 32'd11) begin
      n_fail++; $display("FAIL rw_first_push: got %h/%h want 00000555/0000000b", id_encoded, id_rs1_val); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_illegal();
    test_rd0();
    test_flush();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scarv_cop_issue.md
SCARV_COP_ISSUE -- requirements
Module: scarv_cop_issue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, instruction queue depth; legal values 2 or 4.
REQ-002 SHALL have ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_reset  in  1  asynchronous, active-high reset.
- cpu_insn_req  in  1  CPU offers an instruction.
- cpu_insn_ack  out  1  issue block accepts the offered instruction.
- cpu_insn_enc  in  32  encoded instruction.
- cpu_rs1_val  in  32  GPR rs1 value captured with the instruction.
- cpu_flush  in  1  discard queued, undispatched instructions.
- cpu_rsp_valid  out  1  response available.
- cpu_rsp_ack  in  1  CPU consumes the response.
- cpu_rsp_wen  out  1  GPR write enable.
- cpu_rsp_rd  out  5  GPR destination.
- cpu_rsp_wdata  out  32  GPR write data.
- cpu_rsp_status  out  3  000 OK, 001 ILLEGAL, others from execute.
- id_encoded  out  32  queue-head encoding to the decoder.
- id_rs1_val  out  32  queue-head rs1 value.
- id_exception  in  1  decoder flags id_encoded illegal, combinationally.
- id_valid  out  1  dispatch request to execute.
- id_ready  in  1  execute accepts dispatch.
- cop_done  in  1  execute completion pulse.
- cop_wen  in  1  completion write enable.
- cop_rd  in  5  completion destination.
- cop_wdata  in  32  completion data.
- cop_status  in  3  completion status.

Function
REQ-003 SHALL hold FIFO_DEPTH entries of {enc[31:0], rs1[31:0]} in a circular buffer with wrapping read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-004 SHALL drive cpu_insn_ack = !full && !cpu_flush, and push an entry when cpu_insn_req && cpu_insn_ack.
REQ-005 SHALL drive id_encoded/id_rs1_val from the head entry, and drive zero when empty.
REQ-006 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-007 In IDLE, SHALL drive id_valid = !empty && !id_exception.
REQ-008 In IDLE, when id_valid && id_ready, SHALL pop the head and go to WAIT.
REQ-009 In IDLE, when the queue is non-empty and id_exception=1, SHALL pop the head, load response {wen=0, rd=enc[11:7], wdata=0, status=001}, and go to RESP; id_valid SHALL stay 0.
REQ-010 In WAIT, on cop_done, SHALL capture cop_wen/rd/wdata/status into the response register and go to RESP.
REQ-011 SHALL ignore cop_done outside WAIT.
REQ-012 In RESP, SHALL hold cpu_rsp_valid=1 and all response fields stable until cpu_rsp_ack, then go to IDLE; cpu_rsp_valid SHALL be 0 in IDLE and WAIT.
REQ-013 SHALL force cpu_rsp_wen to 0 when cpu_rsp_rd=0.
REQ-014 SHALL have at most one instruction in execute or response; responses are strictly in order.
REQ-015 Latency: push at edge N makes the head visible after N, so id_valid is earliest 1 in the cycle after N. An illegal instruction yields cpu_rsp_valid in the cycle after the pop edge.
REQ-016 SHALL allow push and pop on the same edge when not full; occupancy is then unchanged.
REQ-017 A pop when empty and a push when full SHALL be impossible by construction.
REQ-018 cpu_flush SHALL empty the queue at the next edge (count=0, rptr=wptr), with flush taking priority over a same-cycle push and pop.
REQ-019 cpu_flush SHALL NOT abort a WAIT or RESP instruction.
REQ-020 If cpu_flush=1 in IDLE, SHALL drive id_valid = 0.

Reset
REQ-021 On g_reset=1 (asynchronous), SHALL set state IDLE, the queue empty with pointers 0, and the response register 0.
REQ-022 During reset, cpu_insn_ack, id_valid and cpu_rsp_valid SHALL be 0.
REQ-023 Reset asserted mid-WAIT or mid-RESP SHALL discard the in-flight instruction with no response.
REQ-024 After reset release, the first edge SHALL accept a push.

Verification
REQ-025 Push enc=0x0000_002B, rs1=5. With id_ready=1, id_exception=0 -> id_valid the next cycle, and the queue is empty after dispatch. Then cop_done with wen=1, rd=3, wdata=0xCAFE, status=0 -> cpu_rsp_valid, rd=3, wdata=0xCAFE, wen=1.
REQ-026 Hold id_ready=0 and push FIFO_DEPTH instructions -> cpu_insn_ack=0 on the next offer. Release id_ready -> dispatch occurs in push order, across pointer wrap.
REQ-027 Push with id_exception=1 -> no id_valid, and cpu_rsp_status=001, wen=0. Hold cpu_rsp_ack=0 for 5 cycles -> response stable throughout.
REQ-028 Return a completion with rd=0, wen=1 -> cpu_rsp_wen=0.
REQ-029 Queue 2 entries while in WAIT, then assert cpu_flush with a simultaneous cpu_insn_req -> queue empty, push dropped, and the WAIT instruction still responds.
REQ-030 Assert g_reset mid-WAIT, then send cop_done after release -> no cpu_rsp_valid, and all outputs 0.
